// File: rtl/burst_ram_slave.sv
// rtl/burst_ram_slave.sv - word-addressed burst RAM responder with self-initialising contents
//
// Purpose:
//   Far end of a cache refill/writeback path. It accepts single-beat and burst
//   reads and writes on a pipelined read/write bus, and returns read data with a
//   valid strobe. After reset it sweeps every word with a known pattern, either
//   i*i or zero, before it accepts any request.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   ADDR_W       word-index width, derived from DEPTH
//   INIT_SQUARES 1: word i starts as i*i (low 32 bits); 0: all words start as zero
//
// Ports:
//   clk                    clock, rising edge
//   rest                   asynchronous active-low reset
//   s0_address    [31:0]   byte address; word index = s0_address[ADDR_W+1:2]
//   s0_byteEnable [3:0]    per-byte write enable (writes only)
//   s0_read                read request
//   s0_write               write request, one per beat
//   s0_writeData  [31:0]   write data
//   s0_beginBurstTransfer  informational, ignored
//   s0_burstCount [7:0]    beats in the transfer, 0 treated as 1
//   s0_readData   [31:0]   registered read data
//   s0_readDataValid       s0_readData holds a beat this cycle
//   s0_waitRequest         1 = request not accepted this cycle
`timescale 1ns/1ps

module burst_ram_slave #(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int INIT_SQUARES = 1
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] s0_address,
    input  logic [3:0]  s0_byteEnable,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [31:0] s0_writeData,
    input  logic        s0_beginBurstTransfer,
    input  logic [7:0]  s0_burstCount,
    output logic [31:0] s0_readData,
    output logic        s0_readDataValid,
    output logic        s0_waitRequest
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_WR_BURST = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [31:0]       r_mem [DEPTH];

    state_t            r_state;
    state_t            w_next_state;

    logic [ADDR_W-1:0] r_init_idx;
    logic [31:0]       r_init_sq;      // always equals r_init_idx squared (mod 2^32)
    logic [ADDR_W-1:0] r_base;
    logic [7:0]        r_beat;
    logic [7:0]        r_last;         // index of the final beat, i.e. B-1

    logic [ADDR_W-1:0] w_req_idx;
    logic [7:0]        w_req_last;
    logic [ADDR_W-1:0] w_beat_idx;
    logic              w_accept_rd;
    logic              w_accept_wr;
    logic              w_wait;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_idx;
    logic [31:0]       w_mem_wdata;
    logic [3:0]        w_mem_be;

    // Address bits outside the word index and the burst marker carry no meaning here.
    logic              w_unused;
    assign w_unused = ^{s0_beginBurstTransfer, s0_address[31:ADDR_W+2], s0_address[1:0]};

    assign w_req_idx  = s0_address[ADDR_W+1:2];
    assign w_req_last = (s0_burstCount == 8'd0) ? 8'd0 : (s0_burstCount - 8'd1);
    // Wraps naturally modulo DEPTH because the sum is truncated to ADDR_W bits.
    assign w_beat_idx = r_base + ADDR_W'(r_beat);

    assign s0_waitRequest = w_wait;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wait       = 1'b1;
        w_accept_rd  = 1'b0;
        w_accept_wr  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_idx == LAST_IDX) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_wait = 1'b0;
                // A write wins when both strobes are raised; the read is dropped.
                if (s0_write) begin
                    w_accept_wr = 1'b1;
                    if (w_req_last != 8'd0) begin
                        w_next_state = ST_WR_BURST;
                    end
                end else if (s0_read) begin
                    w_accept_rd  = 1'b1;
                    w_next_state = ST_RD_BURST;
                end
            end
            ST_RD_BURST: begin
                if (r_beat == r_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                w_wait = 1'b0;
                if (s0_write && (r_beat == r_last)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Init sweep and burst counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_init_idx <= '0;
            r_init_sq  <= '0;
            r_base     <= '0;
            r_beat     <= '0;
            r_last     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    // (i+1)^2 = i^2 + 2i + 1, so the sweep needs no multiplier.
                    r_init_sq  <= r_init_sq + (32'(r_init_idx) << 1) + 32'd1;
                end
                ST_IDLE: begin
                    if (w_accept_wr || w_accept_rd) begin
                        r_base <= w_req_idx;
                        r_last <= w_req_last;
                        // The first write beat lands on the accepting edge, so a
                        // write burst continues from beat 1.
                        r_beat <= w_accept_wr ? 8'd1 : 8'd0;
                    end
                end
                ST_RD_BURST: begin
                    r_beat <= r_beat + 8'd1;
                end
                ST_WR_BURST: begin
                    if (s0_write) begin
                        r_beat <= r_beat + 8'd1;
                    end
                end
                default: begin
                    r_beat <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single RAM write port: init sweep, accepting write beat, burst beats
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_beat_idx;
        w_mem_wdata = s0_writeData;
        w_mem_be    = s0_byteEnable;
        case (r_state)
            ST_INIT: begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_init_idx;
                w_mem_wdata = (INIT_SQUARES != 0) ? r_init_sq : 32'd0;
                w_mem_be    = 4'hF;
            end
            ST_IDLE: begin
                w_mem_we  = w_accept_wr;
                w_mem_idx = w_req_idx;
            end
            ST_WR_BURST: begin
                w_mem_we = s0_write;
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read path: one beat per cycle while in RD_BURST
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            s0_readData      <= '0;
            s0_readDataValid <= 1'b0;
        end else if (r_state == ST_RD_BURST) begin
            s0_readData      <= r_mem[w_beat_idx];
            s0_readDataValid <= 1'b1;
        end else begin
            s0_readDataValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_burst_ram_slave.sv
// tb/tb_burst_ram_slave.sv - self-checking bench for burst_ram_slave
`timescale 1ns/1ps

module tb_burst_ram_slave;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rest;
    logic [31:0] s0_address;
    logic [3:0]  s0_byteEnable;
    logic        s0_read;
    logic        s0_write;
    logic [31:0] s0_writeData;
    logic        s0_beginBurstTransfer;
    logic [7:0]  s0_burstCount;
    logic [31:0] s0_readData;
    logic        s0_readDataValid;
    logic        s0_waitRequest;

    burst_ram_slave #(
        .DEPTH(DEPTH),
        .INIT_SQUARES(1)
    ) dut (
        .clk                  (clk),
        .rest                 (rest),
        .s0_address           (s0_address),
        .s0_byteEnable        (s0_byteEnable),
        .s0_read              (s0_read),
        .s0_write             (s0_write),
        .s0_writeData         (s0_writeData),
        .s0_beginBurstTransfer(s0_beginBurstTransfer),
        .s0_burstCount        (s0_burstCount),
        .s0_readData          (s0_readData),
        .s0_readDataValid     (s0_readDataValid),
        .s0_waitRequest       (s0_waitRequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  bc;
        int          n;
        logic [31:0] exp [8];
    } rd_vec_t;

    rd_vec_t     vecs [6];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] rd_data [256];
    int          rd_cnt;
    logic [31:0] wr_data [256];
    logic [3:0]  wr_be [256];
    int          wr_stall [256];
    int          total;
    int          bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i * i);
    endtask

    // All tasks start and end at a sampling point one time unit after a rising edge.
    task automatic wait_ready();
        int n;
        n = 0;
        while (s0_waitRequest !== 1'b0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (s0_waitRequest !== 1'b0) check("ready_timeout", {31'd0, s0_waitRequest}, 32'd0);
    endtask

    task automatic count_init();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (s0_waitRequest === 1'b1 && n < 3000);
        check("init_cycles", 32'(n), 32'(DEPTH));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] bc);
        int nb;
        int wait_hi;
        logic vpat_ok;
        nb = (bc == 8'd0) ? 1 : int'(bc);
        wait_ready();
        s0_address    = addr;
        s0_burstCount = bc;
        s0_read       = 1'b1;
        @(posedge clk); #1;
        s0_read       = 1'b0;
        s0_address    = $urandom;
        rd_cnt  = 0;
        wait_hi = 0;
        vpat_ok = 1'b1;
        for (int c = 0; c <= nb + 2; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (s0_waitRequest === 1'b1) wait_hi++;
            if (s0_readDataValid !== ((c >= 1 && c <= nb) ? 1'b1 : 1'b0)) vpat_ok = 1'b0;
            if (s0_readDataValid === 1'b1 && rd_cnt < 256) begin
                rd_data[rd_cnt] = s0_readData;
                rd_cnt++;
            end
        end
        check("rd_wait_cycles", 32'(wait_hi), 32'(nb));
        check("rd_valid_timing", {31'd0, vpat_ok}, 32'd1);
        check("rd_beat_count", 32'(rd_cnt), 32'(nb));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] bc);
        int nb;
        int base;
        nb   = (bc == 8'd0) ? 1 : int'(bc);
        base = int'(addr[11:2]);
        wait_ready();
        s0_address    = addr;
        s0_burstCount = bc;
        s0_write      = 1'b1;
        s0_writeData  = wr_data[0];
        s0_byteEnable = wr_be[0];
        @(posedge clk); #1;
        ref_mem[base] = merge(ref_mem[base], wr_data[0], wr_be[0]);
        for (int n = 1; n < nb; n++) begin
            s0_address = $urandom;
            for (int s = 0; s < wr_stall[n]; s++) begin
                s0_write      = 1'b0;
                s0_read       = 1'b1;
                s0_byteEnable = 4'($urandom);
                @(posedge clk); #1;
            end
            s0_read = 1'b0;
            check("wr_burst_ready", {31'd0, s0_waitRequest}, 32'd0);
            s0_write      = 1'b1;
            s0_writeData  = wr_data[n];
            s0_byteEnable = wr_be[n];
            @(posedge clk); #1;
            ref_mem[(base + n) % DEPTH] = merge(ref_mem[(base + n) % DEPTH], wr_data[n], wr_be[n]);
        end
        s0_write = 1'b0;
        s0_read  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic vflag;
        int   idx;
        int   nb;
        int   op;
        logic [31:0] a;
        logic [7:0]  bc;

        total = 0;
        bad   = 0;
        rest  = 1'b0;
        s0_address = '0;
        s0_byteEnable = 4'hF;
        s0_read = 1'b0;
        s0_write = 1'b0;
        s0_writeData = '0;
        s0_beginBurstTransfer = 1'b0;
        s0_burstCount = 8'd1;
        model_init();

        vecs[0].addr = 32'd0;    vecs[0].bc = 8'd1; vecs[0].n = 1; vecs[0].exp[0] = 32'd0;
        vecs[1].addr = 32'd4;    vecs[1].bc = 8'd1; vecs[1].n = 1; vecs[1].exp[0] = 32'd1;
        vecs[2].addr = 32'd4092; vecs[2].bc = 8'd1; vecs[2].n = 1; vecs[2].exp[0] = 32'd1046529;
        vecs[3].addr = 32'd16;   vecs[3].bc = 8'd8; vecs[3].n = 8;
        vecs[3].exp[0] = 32'd16; vecs[3].exp[1] = 32'd25; vecs[3].exp[2] = 32'd36;
        vecs[3].exp[3] = 32'd49; vecs[3].exp[4] = 32'd64; vecs[3].exp[5] = 32'd81;
        vecs[3].exp[6] = 32'd100; vecs[3].exp[7] = 32'd121;
        vecs[4].addr = 32'd4092; vecs[4].bc = 8'd2; vecs[4].n = 2;
        vecs[4].exp[0] = 32'd1046529; vecs[4].exp[1] = 32'd0;
        vecs[5].addr = 32'd8;    vecs[5].bc = 8'd0; vecs[5].n = 1; vecs[5].exp[0] = 32'd4;

        #23;
        check("reset_wait", {31'd0, s0_waitRequest}, 32'd1);
        check("reset_valid", {31'd0, s0_readDataValid}, 32'd0);
        check("reset_rdata", s0_readData, 32'd0);
        @(posedge clk); #1;
        rest = 1'b1;
        count_init();

        for (int i = 0; i < 6; i++) begin
            do_read(vecs[i].addr, vecs[i].bc);
            for (int n = 0; n < vecs[i].n; n++) begin
                check($sformatf("vec%0d_beat%0d", i, n), rd_data[n], vecs[i].exp[n]);
            end
        end

        // Burst write with a stall between beats 1 and 2 and partial byte enables.
        wr_data[0] = 32'hA0; wr_be[0] = 4'hF; wr_stall[0] = 0;
        wr_data[1] = 32'hA1; wr_be[1] = 4'hF; wr_stall[1] = 0;
        wr_data[2] = 32'hA2; wr_be[2] = 4'b0011; wr_stall[2] = 1;
        wr_data[3] = 32'hA3; wr_be[3] = 4'hF; wr_stall[3] = 0;
        do_write(32'h40, 8'd4);
        do_read(32'h40, 8'd4);
        check("wrb_beat0", rd_data[0], 32'hA0);
        check("wrb_beat1", rd_data[1], 32'hA1);
        check("wrb_beat2", rd_data[2], 32'h000000A2);
        check("wrb_beat3", rd_data[3], 32'hA3);

        // Simultaneous read and write: write wins, no read data returned.
        wait_ready();
        s0_address = 32'd12; s0_writeData = 32'h55; s0_byteEnable = 4'hF;
        s0_burstCount = 8'd1; s0_read = 1'b1; s0_write = 1'b1;
        @(posedge clk); #1;
        s0_read = 1'b0; s0_write = 1'b0;
        ref_mem[3] = 32'h55;
        vflag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (s0_readDataValid !== 1'b0) vflag = 1'b1;
            @(posedge clk); #1;
        end
        check("rw_no_valid", {31'd0, vflag}, 32'd0);
        do_read(32'd12, 8'd1);
        check("rw_readback", rd_data[0], 32'h55);

        // Randomised traffic against the reference array.
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 9);
            a  = $urandom;
            if (op == 9) a[11:2] = 10'(DEPTH - $urandom_range(1, 3));
            bc = 8'($urandom_range(0, 6));
            nb = (bc == 8'd0) ? 1 : int'(bc);
            idx = int'(a[11:2]);
            if (op < 5 || op == 9) begin
                do_read(a, bc);
                for (int n = 0; n < nb; n++) begin
                    check($sformatf("rand%0d_rd%0d", t, n), rd_data[n], ref_mem[(idx + n) % DEPTH]);
                end
            end else begin
                for (int n = 0; n < nb; n++) begin
                    wr_data[n]  = $urandom;
                    wr_be[n]    = 4'($urandom);
                    wr_stall[n] = $urandom_range(0, 2);
                end
                do_write(a, bc);
            end
        end

        // Reset in the middle of an 8-beat read.
        wait_ready();
        s0_address = 32'd0; s0_burstCount = 8'd8; s0_read = 1'b1;
        @(posedge clk); #1;
        s0_read = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
        end
        check("midrst_beat3_valid", {31'd0, s0_readDataValid}, 32'd1);
        check("midrst_beat3_data", s0_readData, ref_mem[3]);
        #2;
        rest = 1'b0;
        #1;
        check("midrst_valid_drop", {31'd0, s0_readDataValid}, 32'd0);
        check("midrst_wait", {31'd0, s0_waitRequest}, 32'd1);
        check("midrst_rdata", s0_readData, 32'd0);
        vflag = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (s0_readDataValid !== 1'b0) vflag = 1'b1;
        end
        check("midrst_no_beats", {31'd0, vflag}, 32'd0);
        rest = 1'b1;
        model_init();
        count_init();
        do_read(32'h40, 8'd1);
        check("reinit_word16", rd_data[0], 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_ram_slave.md
# burst_ram_slave

Synthesizable word-addressed memory responder for the cache's `m0` master port, i.e. the far end of the cache's refill/writeback path. It accepts single-beat and burst reads and writes on the same pipelined read/write bus the cache drives, with `readDataValid` signalling. After reset it fills itself with a known pattern so cache benches can check refill data without a behavioural model. It replaces the non-burst simulation model in cache benches and in FPGA bring-up.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `ADDR_W`, `$clog2(DEPTH)`: word-index width; derived, not overridden.
- `INIT_SQUARES`, 1: 1 = word i initialised to i*i (low 32 bits); 0 = all zeros.

Ports. One clock; reset is asynchronous and active-low (`clk`, `rest`).
- `clk` in 1: clock; all state changes on the rising edge.
- `rest` in 1: asynchronous active-low reset.
- `s0_address` in 32: byte address; word index = `s0_address[ADDR_W+1:2]`; bits [1:0] and the upper bits are ignored.
- `s0_byteEnable` in 4: per-byte write enable; ignored on reads.
- `s0_read` in 1: read request.
- `s0_write` in 1: write request, one per beat.
- `s0_writeData` in 32: write data.
- `s0_beginBurstTransfer` in 1: informational; ignored.
- `s0_burstCount` in 8: beats in the transfer; sampled on the accepting edge; 0 is treated as 1.
- `s0_readData` out 32: read data, registered.
- `s0_readDataValid` out 1: `s0_readData` is valid this cycle.
- `s0_waitRequest` out 1: combinational from state; 1 = request not accepted.

## Operation
- **States:** INIT, IDLE, RD_BURST, WR_BURST.
- **INIT**
  - Entered on reset.
  - A counter sweeps word 0..DEPTH-1, writing one word per cycle: idx*idx truncated to 32 bits, or 0 when `INIT_SQUARES`=0.
  - `s0_waitRequest`=1 throughout.
  - Goes to IDLE on the edge that writes word DEPTH-1, so INIT lasts exactly DEPTH cycles.
- **IDLE**
  - `s0_waitRequest`=0.
  - A request is accepted on an edge where `s0_read` or `s0_write` is 1.
  - If both are 1, the write is accepted and the read is dropped.
  - On acceptance: base word index and beat count B (0 becomes 1) are latched, and the beat counter is cleared.
- **RD_BURST**
  - `s0_waitRequest`=1.
  - Beat n returns `mem[(base+n) mod DEPTH]` using a synchronous RAM read.
  - Returns to IDLE on the edge that registers beat B-1.
  - `s0_read`/`s0_write` are ignored while in this state.
- **WR_BURST**
  - The first beat is written on the accepting edge itself, with `s0_byteEnable` applied per byte.
  - If B=1, the state stays IDLE and WR_BURST is not entered.
  - Otherwise the block enters WR_BURST with `s0_waitRequest`=0.
  - Each further edge with `s0_write`=1 writes word `(base+n) mod DEPTH` and increments n. Edges with `s0_write`=0 are stalls.
  - Returns to IDLE after beat B-1.
  - `s0_read` is ignored in WR_BURST.
  - `s0_address` is ignored after the first beat.
- **Address wrap:** word addresses wrap modulo DEPTH inside a burst.
- **Reset mid-operation:** in-flight beats are dropped, outputs take their reset values, and the INIT sweep restarts from word 0.

## Timing
- **Reset values:** `s0_waitRequest`=1, `s0_readDataValid`=0, `s0_readData`=0, state INIT, counters 0.
- **Read accepted at edge k with B beats:**
  - `s0_readDataValid`=1 with beat n on `s0_readData` during the cycle following edge k+1+n, for n=0..B-1. Beats are back-to-back with no gaps.
  - `s0_waitRequest` returns to 0 after edge k+B.
  - The next request is accepted at the earliest at edge k+B+1.
  - `s0_readDataValid` falls after edge k+B+1.
  - Single-word read latency is 2 edges: accept at k, data sampled at k+2.
- **Write:** a write at edge k is visible to a read accepted at edge k+1 or later. There is no read-during-write hazard.
- **Back-to-back single writes:** sustainable at one per cycle.
- **After reset release:** the first accept edge is DEPTH edges after the first rising edge with `rest`=1.

## Test plan
- **Init pattern:** DEPTH=1024, `INIT_SQUARES`=1. Wait for `s0_waitRequest`=0, then do single reads at byte addresses 0, 4, 4092 -> data 0, 1, 1046529.
- **Burst read:** B=8 at byte address 16 -> 8 consecutive valid beats 16, 25, 36, 49, 64, 81, 100, 121; `s0_waitRequest` high for exactly 8 cycles.
- **Burst write with stalls:** B=4 at byte address 0x40; data 0xA0..0xA3; beat 2 with `s0_byteEnable`=4'b0011; one idle cycle (`s0_write`=0) between beats 1 and 2. Read back B=4 -> 0xA0, 0xA1, (16*16... word 18: 324 upper bytes kept, lower bytes 0x00A2) = 0x000000A2, 0xA3.
- **Wrap and burstCount=0:** B=2 at byte address 4092 -> 1046529 then 0. A read with `s0_burstCount`=0 at address 8 -> exactly one beat of value 4.
- **Simultaneous read+write:** `s0_read`=`s0_write`=1 in IDLE, address 12, data 0x55, B=1 -> no `s0_readDataValid` pulse; a later read of address 12 returns 0x55.
- **Reset mid-burst:** drop `rest` during beat 3 of a B=8 read -> `s0_readDataValid` falls immediately with no further beats. After release, `s0_waitRequest`=1 for 1024 cycles, then a read of address 0x40 returns 256 (the earlier write is overwritten by the re-init).
